// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// midi_pkg : shared MIDI constants, FSM state encodings and baud-rate helper
// Rev 1.0
// ============================================================================
package midi_pkg;

  localparam logic [3:0] NOTE_OFF     = 4'h8;
  localparam logic [3:0] NOTE_ON      = 4'h9;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_t;

  typedef enum logic [1:0] {
    P_STATUS = 2'd0,
    P_DATA1  = 2'd1,
    P_DATA2  = 2'd2
  } parse_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// uart_rx_byte : 8N1 receiver with 2-FF input synchronizer and framing check
// Rev 1.0
// ============================================================================
module uart_rx_byte
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 3200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'((CLKS_PER_BIT / 2) - 1);

  logic             rx_meta;
  logic             rx_sync;
  uart_state_t      state;
  uart_state_t      state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_next;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_cnt_next;
  logic [7:0]       shift;
  logic [7:0]       shift_next;
  logic             byte_valid_next;
  logic             framing_err_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_sync     <= rx_meta;
      state       <= state_next;
      baud_cnt    <= baud_cnt_next;
      bit_cnt     <= bit_cnt_next;
      shift       <= shift_next;
      byte_valid  <= byte_valid_next;
      framing_err <= framing_err_next;
    end
  end

  always_comb begin
    state_next       = state;
    baud_cnt_next    = baud_cnt;
    bit_cnt_next     = bit_cnt;
    shift_next       = shift;
    byte_valid_next  = 1'b0;
    framing_err_next = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_next    = START;
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
        end
      end

      // Half a bit in, re-check the line so short glitches are rejected.
      START: begin
        if (baud_cnt == HALF_MAX) begin
          baud_cnt_next = '0;
          state_next    = rx_sync ? IDLE : DATA;
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (baud_cnt == FULL_MAX) begin
          baud_cnt_next = '0;
          shift_next    = {rx_sync, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        if (baud_cnt == FULL_MAX) begin
          baud_cnt_next = '0;
          if (rx_sync) begin
            byte_valid_next = 1'b1;
            state_next      = IDLE;
          end else begin
            framing_err_next = 1'b1;
            state_next       = WAIT_HIGH;
          end
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end

      WAIT_HIGH: begin
        if (rx_sync) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // The shift register only moves in DATA, so it is stable while byte_valid is high.
  assign data = shift;

endmodule
`default_nettype wire

// File: rtl/midi_uart_rx.sv
`default_nettype none
// ============================================================================
// midi_uart_rx : MIDI serial front end, Note On/Off parser with running status
// Rev 1.0
// ============================================================================
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 31250,
  parameter int CHANNEL  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_rx,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic       note_on,
  output logic [6:0] velocity,
  output logic       framing_err
);

  localparam int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam bit         ACCEPT_ALL   = (CHANNEL > 15);
  localparam logic [3:0] CHAN_SEL     = 4'(CHANNEL);

  logic [7:0]   rx_byte;
  logic         rx_valid;

  parse_state_t pstate;
  parse_state_t pstate_next;
  logic         running;
  logic         running_next;
  logic         on_status;
  logic         on_status_next;
  logic [6:0]   note;
  logic [6:0]   note_next;
  logic [7:0]   data_next;
  logic         valid_next;
  logic         note_on_next;
  logic [6:0]   vel_next;

  logic         is_realtime;
  logic         is_note_status;
  logic         chan_ok;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (midi_rx),
    .data        (rx_byte),
    .byte_valid  (rx_valid),
    .framing_err (framing_err)
  );

  assign is_realtime    = (rx_byte >= REALTIME_MIN);
  assign is_note_status = (rx_byte[7:4] == NOTE_OFF) || (rx_byte[7:4] == NOTE_ON);
  assign chan_ok        = ACCEPT_ALL || (rx_byte[3:0] == CHAN_SEL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pstate     <= P_STATUS;
      running    <= 1'b0;
      on_status  <= 1'b0;
      note       <= '0;
      midi_data  <= '0;
      midi_valid <= 1'b0;
      note_on    <= 1'b0;
      velocity   <= '0;
    end else begin
      pstate     <= pstate_next;
      running    <= running_next;
      on_status  <= on_status_next;
      note       <= note_next;
      midi_data  <= data_next;
      midi_valid <= valid_next;
      note_on    <= note_on_next;
      velocity   <= vel_next;
    end
  end

  // Realtime bytes fall through untouched so they can sit between data bytes.
  always_comb begin
    pstate_next    = pstate;
    running_next   = running;
    on_status_next = on_status;
    note_next      = note;
    data_next      = midi_data;
    valid_next     = 1'b0;
    note_on_next   = note_on;
    vel_next       = velocity;

    if (rx_valid && !is_realtime) begin
      if (rx_byte[7]) begin
        if (is_note_status && chan_ok) begin
          running_next   = 1'b1;
          on_status_next = (rx_byte[7:4] == NOTE_ON);
          pstate_next    = P_DATA1;
        end else begin
          running_next = 1'b0;
          pstate_next  = P_STATUS;
        end
      end else begin
        unique case (pstate)
          P_STATUS: begin
            if (running) begin
              note_next   = rx_byte[6:0];
              pstate_next = P_DATA2;
            end
          end
          P_DATA1: begin
            note_next   = rx_byte[6:0];
            pstate_next = P_DATA2;
          end
          P_DATA2: begin
            vel_next     = rx_byte[6:0];
            data_next    = {1'b0, note};
            note_on_next = on_status && (rx_byte[6:0] != 7'd0);
            valid_next   = 1'b1;
            pstate_next  = P_DATA1;
          end
          default: pstate_next = P_STATUS;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_midi_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_midi_uart_rx : scoreboard bench, two DUTs (omni and channel 0) on one line
// Rev 1.0
// ============================================================================
module tb_midi_uart_rx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 31250;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;

  typedef struct {
    logic [6:0]  note;
    logic        on;
    logic [6:0]  vel;
    int unsigned lo;
    int unsigned hi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] md [2];
  logic       mv [2];
  logic       non [2];
  logic [6:0] vel [2];
  logic       fe [2];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          fe_exp = 0;
  int          fe_seen [2];

  exp_t        exp_q [2][$];
  logic [7:0]  m_rs [2];
  int          m_cnt [2];
  logic [6:0]  m_note [2];
  logic [7:0]  l_data [2];
  logic        l_on [2];
  logic [6:0]  l_vel [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  midi_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .CHANNEL(16)) dut_omni (
    .clk(clk), .rst_n(rst_n), .midi_rx(rx), .midi_data(md[0]), .midi_valid(mv[0]),
    .note_on(non[0]), .velocity(vel[0]), .framing_err(fe[0])
  );

  midi_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .CHANNEL(0)) dut_ch0 (
    .clk(clk), .rst_n(rst_n), .midi_rx(rx), .midi_data(md[1]), .midi_valid(mv[1]),
    .note_on(non[1]), .velocity(vel[1]), .framing_err(fe[1])
  );

  // Reference: byte-stream interpretation of the MIDI rules, one instance per DUT.
  task automatic model_byte(input int d, input logic [7:0] b, input int unsigned c);
    exp_t e;
    int   chan_cfg;
    chan_cfg = (d == 0) ? 16 : 0;
    if (b >= 8'hF8) return;
    if (b >= 8'h80) begin
      m_cnt[d] = 0;
      if ((b / 16 == 8 || b / 16 == 9) && (chan_cfg == 16 || int'(b % 16) == chan_cfg))
        m_rs[d] = b;
      else
        m_rs[d] = 8'h00;
      return;
    end
    if (m_rs[d] == 8'h00) return;
    if (m_cnt[d] == 0) begin
      m_note[d] = b[6:0];
      m_cnt[d]  = 1;
    end else begin
      e.note = m_note[d];
      e.vel  = b[6:0];
      e.on   = (m_rs[d] / 16 == 9) && (b != 8'h00);
      e.lo   = c + 9 * CPB + HALF;
      e.hi   = c + 9 * CPB + HALF + 8;
      exp_q[d].push_back(e);
      m_cnt[d] = 0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rs[d]  = 8'h00;
      m_cnt[d] = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    int unsigned c;
    c = cyc;
    if (bad_stop) fe_exp++;
    else for (int d = 0; d < 2; d++) model_byte(d, b, c);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (bad_stop) repeat (4) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic glitch();
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    idle(CPB);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      checks += 5;
      if (md[d] !== 8'd0)  begin errors++; $display("FAIL %s_data dut%0d: got %0h want 0", tag, d, md[d]); end
      if (mv[d] !== 1'b0)  begin errors++; $display("FAIL %s_valid dut%0d: got %b want 0", tag, d, mv[d]); end
      if (non[d] !== 1'b0) begin errors++; $display("FAIL %s_note_on dut%0d: got %b want 0", tag, d, non[d]); end
      if (vel[d] !== 7'd0) begin errors++; $display("FAIL %s_velocity dut%0d: got %0h want 0", tag, d, vel[d]); end
      if (fe[d] !== 1'b0)  begin errors++; $display("FAIL %s_framing dut%0d: got %b want 0", tag, d, fe[d]); end
    end
  endtask

  task automatic send_seq(input logic [7:0] bytes [$]);
    foreach (bytes[i]) send_byte(bytes[i], 1'b0);
  endtask

  // Monitor: pops the scoreboard on every midi_valid, checks hold in between.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        l_data[d] = 8'd0;
        l_on[d]   = 1'b0;
        l_vel[d]  = 7'd0;
      end else begin
        if (fe[d] === 1'b1) fe_seen[d]++;
        if (mv[d] === 1'b1) begin
          checks++;
          if (exp_q[d].size() == 0) begin
            errors++;
            $display("FAIL unexpected_event dut%0d: got note=%0d on=%b vel=%0d want no event", d, md[d], non[d], vel[d]);
            l_data[d] = md[d];
            l_on[d]   = non[d];
            l_vel[d]  = vel[d];
          end else begin
            exp_t e;
            e = exp_q[d].pop_front();
            if (md[d] !== {1'b0, e.note} || non[d] !== e.on || vel[d] !== e.vel || cyc < e.lo || cyc > e.hi) begin
              errors++;
              $display("FAIL event dut%0d: got note=%0d on=%b vel=%0d cyc=%0d want note=%0d on=%b vel=%0d cyc in [%0d,%0d]",
                       d, md[d], non[d], vel[d], cyc, e.note, e.on, e.vel, e.lo, e.hi);
            end
            l_data[d] = {1'b0, e.note};
            l_on[d]   = e.on;
            l_vel[d]  = e.vel;
          end
        end else begin
          if (exp_q[d].size() != 0 && cyc > exp_q[d][0].hi) begin
            exp_t e;
            e = exp_q[d].pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event dut%0d: got no pulse by cyc %0d want note=%0d vel=%0d", d, cyc, e.note, e.vel);
          end
          checks++;
          if (md[d] !== l_data[d] || non[d] !== l_on[d] || vel[d] !== l_vel[d]) begin
            errors++;
            $display("FAIL hold dut%0d: got note=%0d on=%b vel=%0d want note=%0d on=%b vel=%0d",
                     d, md[d], non[d], vel[d], l_data[d], l_on[d], l_vel[d]);
            l_data[d] = md[d];
            l_on[d]   = non[d];
            l_vel[d]  = vel[d];
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         r;
    fe_seen[0] = 0;
    fe_seen[1] = 0;
    model_reset();

    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(CPB);

    send_seq('{8'h90, 8'h3C, 8'h64});
    idle(2 * CPB);
    send_seq('{8'h90, 8'h3E, 8'h50, 8'h40, 8'h50});
    send_seq('{8'h90, 8'h3C, 8'h00, 8'h80, 8'h40, 8'h40});
    send_seq('{8'h90, 8'h3C, 8'hF8, 8'h64});
    send_seq('{8'h91, 8'h3C, 8'h64});
    send_byte(8'h55, 1'b1);
    send_seq('{8'h90, 8'h40, 8'h7F});
    glitch();
    send_seq('{8'h3C, 8'h64});

    // Reset in the middle of data bit 4 of a note byte.
    send_byte(8'h90, 1'b0);
    b  = 8'h3C;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("midframe_reset");
    model_reset();
    rst_n = 1'b1;
    idle(12 * CPB);
    send_seq('{8'h90, 8'h3C, 8'h64});

    for (int n = 0; n < 90; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15)      b = 8'h80 | 8'($urandom_range(0, 31));
      else if (r < 22) b = ($urandom_range(0, 1) != 0) ? 8'h90 : 8'h80;
      else if (r < 26) b = 8'($urandom_range(8'hA0, 8'hF7));
      else if (r < 31) b = 8'($urandom_range(8'hF8, 8'hFF));
      else             b = 8'($urandom_range(0, 127));
      send_byte(b, ($urandom_range(0, 99) < 4));
      if ($urandom_range(0, 99) < 5) glitch();
      if ($urandom_range(0, 1) != 0) idle(int'($urandom_range(1, 2 * CPB)));
    end

    idle(12 * CPB);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (exp_q[d].size() != 0) begin
        errors++;
        $display("FAIL leftover dut%0d: got %0d pending events want 0", d, exp_q[d].size());
      end
      checks++;
      if (fe_seen[d] != fe_exp) begin
        errors++;
        $display("FAIL framing_count dut%0d: got %0d pulses want %0d", d, fe_seen[d], fe_exp);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/midi_uart_rx.md
Name: midi_uart_rx

Overview:
Serial MIDI front end that sits directly upstream of midi_player. It receives the 31250-baud MIDI UART line and parses Note On and Note Off messages, including running status. For each completed note message it emits the note number on midi_data with a one-cycle midi_valid pulse, matching the midi_player input contract.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD, 31250, MIDI line rate in baud; CLKS_PER_BIT = CLK_FREQ/BAUD (3200 at defaults).
CHANNEL, 16, MIDI channel filter: 0-15 accepts that channel only, 16 accepts all channels.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
midi_rx  in  1  asynchronous serial MIDI line; idles high.
midi_data  out  8  note number, zero-extended {1'b0, note[6:0]}.
midi_valid  out  1  one-cycle pulse: a new note event is on midi_data, note_on and velocity.
note_on  out  1  1 = note on with velocity > 0; 0 = note off, or note on with velocity 0.
velocity  out  7  velocity byte of the last event.
framing_err  out  1  one-cycle pulse when a stop bit is sampled low.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs go to 0, synchronizer flops go to 1, UART FSM goes to IDLE, parser goes to P_STATUS, running status is cleared. Reset mid-frame abandons the partial byte.
- Input: 2-FF synchronizer on midi_rx. All decisions use the synchronized level.
- UART FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: synchronized line = 0 -> START, and the bit counter is cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. Line 1 -> false start, go to IDLE. Line 0 -> DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Line 1: internal byte_valid pulses for one cycle, then IDLE.
    - Line 0: framing_err pulses for one cycle, the byte is discarded, then WAIT_HIGH.
  - WAIT_HIGH: stay until the line is 1, then IDLE.
- Parser (consumes byte_valid), states P_STATUS, P_DATA1, P_DATA2.
  - Status 0x8n or 0x9n with the channel accepted: latch the status, set running status, go to P_DATA1.
  - Status 0x8n or 0x9n on a filtered channel, or any other status 0xA0-0xF7: clear running status, go to P_STATUS.
  - Realtime 0xF8-0xFF: ignored completely, with no state change, including between data bytes.
  - Data byte (bit7=0) in P_STATUS with running status valid: treat it as data1. Without running status: discard it.
  - P_DATA1: latch the note, go to P_DATA2.
  - P_DATA2: latch the velocity and emit the event, then go to P_DATA1 (running status retained).
- Emit:
  - midi_valid = 1 for exactly one cycle, on the cycle after byte_valid of data2.
  - midi_data, note_on and velocity update on that same cycle and hold until the next event.
  - note_on = (status nibble = 0x9) AND (velocity != 0).
- Latency: midi_valid rises 2 cycles after the stop-bit sample edge of the final byte.
- Counters: the baud counter is ceil(log2(CLKS_PER_BIT)) bits wide. The bit counter is 3 bits and wraps only via the state transition.
- A new start bit is accepted in IDLE immediately after the stop sample; back-to-back frames are supported.

Decomposition:
- Package midi_pkg holds:
  - status-nibble constants NOTE_OFF=4'h8 and NOTE_ON=4'h9;
  - realtime threshold 8'hF8;
  - state enums for the UART FSM and the parser;
  - a function computing CLKS_PER_BIT from CLK_FREQ and BAUD.
- Sub-module uart_rx_byte contains the synchronizer, the UART FSM, byte_valid and framing_err.
- midi_uart_rx is the top level and holds the parser and output registers.

Test Plan:
- Send bytes 0x90 0x3C 0x64 at 31250 baud -> exactly one midi_valid pulse, midi_data=60, note_on=1, velocity=100, 2 cycles after the last stop sample.
- Running status: send 0x90 0x3E 0x50 0x40 0x50 -> two pulses, midi_data=62 then 64, note_on=1 both times.
- Send 0x90 0x3C 0x00 then 0x80 0x40 0x40 -> two pulses, both with note_on=0; midi_data=60 then 64.
- Send 0x90 0x3C 0xF8 0x64 -> one pulse with midi_data=60, velocity=100. With CHANNEL=0, send 0x91 0x3C 0x64 -> no pulse.
- Framing and glitches:
  - A stop bit held low -> framing_err pulses once and there is no midi_valid. After the line returns high, 0x90 0x40 0x7F -> midi_data=64.
  - A 500-cycle low glitch -> no byte is received.
- Assert rst_n=0 for 3 cycles during data bit 4 of a note byte -> all outputs are 0. A following full 0x90 0x3C 0x64 -> one pulse with midi_data=60.
